// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: state encoding, default
// timing constants and the counter-width helper used by the RTL and the bench.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_EDIT   = 2'd1,
    ST_ALERT  = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV           = 50000;
  localparam int DEF_BLINK_TICKS        = 250;
  localparam int DEF_EDIT_TIMEOUT_TICKS = 5000;
  localparam int DEF_ALERT_TICKS        = 2000;

  // Width of a counter that holds 0..n-1; a single bit when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle between the control core / keypad logic and the display driver,
// with the scheduler on the slave side.
interface display_scheduler_if;

  logic [7:0] dest;
  logic [7:0] curr;
  logic       editReq;
  logic       editDone;
  logic       keyActivity;
  logic       alertReq;
  logic [7:0] alertCode;
  logic       unitToggle;
  logic [7:0] dispDest;
  logic [7:0] dispCurr;
  logic       displayMode;
  logic       blankDest;
  logic [1:0] state;

  modport master (
    output dest, curr, editReq, editDone, keyActivity, alertReq, alertCode, unitToggle,
    input  dispDest, dispCurr, displayMode, blankDest, state
  );

  modport slave (
    input  dest, curr, editReq, editDone, keyActivity, alertReq, alertCode, unitToggle,
    output dispDest, dispCurr, displayMode, blankDest, state
  );

endinterface

// File: rtl/display_scheduler_tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the last count as a tick.
// A clear restarts the count so the next tick lands exactly DIV cycles later.
module tick_prescaler
  import display_scheduler_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic resetN,
  input  logic clear,
  output logic tick
);

  localparam int              W    = cnt_width(DIV);
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_reg <= '0;
    end else if (clear || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/display_scheduler.sv
// Chooses what the temperature display shows (pass-through, blinking setpoint
// edit, or a timed alert code) and owns the hex/decimal mode flag.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int TICK_DIV           = DEF_TICK_DIV,
  parameter int BLINK_TICKS        = DEF_BLINK_TICKS,
  parameter int EDIT_TIMEOUT_TICKS = DEF_EDIT_TIMEOUT_TICKS,
  parameter int ALERT_TICKS        = DEF_ALERT_TICKS
) (
  input  logic                clock,
  input  logic                resetN,
  display_scheduler_if.slave  bus
);

  localparam int BW = cnt_width(BLINK_TICKS);
  localparam int EW = cnt_width(EDIT_TIMEOUT_TICKS);
  localparam int AW = cnt_width(ALERT_TICKS);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [EW-1:0] EDIT_LAST  = EW'(EDIT_TIMEOUT_TICKS - 1);
  localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_TICKS - 1);

  state_t        state_reg, state_next;
  state_t        resume_reg, resume_next;
  logic [7:0]    code_reg, code_next;
  logic          mode_reg, mode_next;
  logic [EW-1:0] edit_cnt_reg, edit_cnt_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blank_reg, blank_next;
  logic [AW-1:0] alert_cnt_reg, alert_cnt_next;
  logic [7:0]    disp_dest_reg, disp_curr_reg;
  logic          display_mode_reg;
  logic          restart;
  logic          prescale_clear;
  logic          tick;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .resetN (resetN),
    .clear  (prescale_clear),
    .tick   (tick)
  );

  // Requests are decoded in priority order; a tick only acts when no request does.
  always_comb begin
    state_next     = state_reg;
    resume_next    = resume_reg;
    code_next      = code_reg;
    mode_next      = mode_reg ^ bus.unitToggle;
    edit_cnt_next  = edit_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    blank_next     = blank_reg;
    alert_cnt_next = alert_cnt_reg;
    restart        = 1'b0;

    case (state_reg)
      ST_NORMAL: begin
        edit_cnt_next  = '0;
        blink_cnt_next = '0;
        alert_cnt_next = '0;
        if (bus.alertReq) begin
          state_next  = ST_ALERT;
          code_next   = bus.alertCode;
          resume_next = (bus.editReq && !bus.editDone) ? ST_EDIT : ST_NORMAL;
        end else if (bus.editReq) begin
          state_next = ST_EDIT;
        end
      end

      ST_EDIT: begin
        alert_cnt_next = '0;
        if (bus.alertReq) begin
          state_next  = ST_ALERT;
          code_next   = bus.alertCode;
          resume_next = bus.editDone ? ST_NORMAL : ST_EDIT;
        end else if (bus.editDone) begin
          state_next = ST_NORMAL;
        end else if (bus.editReq || bus.keyActivity) begin
          restart        = 1'b1;
          edit_cnt_next  = '0;
          blink_cnt_next = '0;
          blank_next     = 1'b0;
        end else if (tick) begin
          if (edit_cnt_reg == EDIT_LAST) begin
            state_next = ST_NORMAL;
          end else begin
            edit_cnt_next = edit_cnt_reg + EW'(1);
            if (blink_cnt_reg == BLINK_LAST) begin
              blink_cnt_next = '0;
              blank_next     = ~blank_reg;
            end else begin
              blink_cnt_next = blink_cnt_reg + BW'(1);
            end
          end
        end
      end

      ST_ALERT: begin
        // Edit timers idle here so a resume into EDIT starts them from zero.
        edit_cnt_next  = '0;
        blink_cnt_next = '0;
        if (bus.alertReq) begin
          restart        = 1'b1;
          code_next      = bus.alertCode;
          alert_cnt_next = '0;
        end else if (bus.editDone) begin
          resume_next = ST_NORMAL;
        end else if (bus.editReq) begin
          resume_next = ST_EDIT;
        end else if (tick) begin
          if (alert_cnt_reg == ALERT_LAST) begin
            state_next     = resume_reg;
            alert_cnt_next = '0;
          end else begin
            alert_cnt_next = alert_cnt_reg + AW'(1);
          end
        end
      end

      default: begin
        state_next = ST_NORMAL;
      end
    endcase

    if (state_next != ST_EDIT) begin
      blank_next = 1'b0;
    end

    prescale_clear = restart || (state_next != state_reg);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg        <= ST_NORMAL;
      resume_reg       <= ST_NORMAL;
      code_reg         <= '0;
      mode_reg         <= 1'b0;
      edit_cnt_reg     <= '0;
      blink_cnt_reg    <= '0;
      blank_reg        <= 1'b0;
      alert_cnt_reg    <= '0;
      disp_dest_reg    <= '0;
      disp_curr_reg    <= '0;
      display_mode_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      resume_reg    <= resume_next;
      code_reg      <= code_next;
      mode_reg      <= mode_next;
      edit_cnt_reg  <= edit_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      blank_reg     <= blank_next;
      alert_cnt_reg <= alert_cnt_next;
      if (state_next == ST_ALERT) begin
        disp_dest_reg    <= code_next;
        disp_curr_reg    <= code_next;
        display_mode_reg <= 1'b0;
      end else begin
        disp_dest_reg    <= bus.dest;
        disp_curr_reg    <= bus.curr;
        display_mode_reg <= mode_next;
      end
    end
  end

  assign bus.dispDest    = disp_dest_reg;
  assign bus.dispCurr    = disp_curr_reg;
  assign bus.displayMode = display_mode_reg;
  assign bus.blankDest   = blank_reg;
  assign bus.state       = state_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench: stimulus queues expected outputs tagged with the clock edge
// they belong to; a negedge monitor pops and compares them.
module tb_display_scheduler;
  import display_scheduler_pkg::*;

  localparam logic [7:0] D  = 8'h47;
  localparam logic [7:0] C  = 8'h19;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] E2 = 8'hE2;
  localparam logic [7:0] A5 = 8'hA5;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  display_scheduler_if bus();

  display_scheduler #(
    .TICK_DIV           (4),
    .BLINK_TICKS        (2),
    .EDIT_TIMEOUT_TICKS (10),
    .ALERT_TICKS        (5)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [1:0] st;
    logic [7:0] dd;
    logic [7:0] dc;
    logic       dm;
    logic       bl;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic void expect_at(input int at, input string name, input logic [1:0] st,
                                    input logic [7:0] dd, input logic [7:0] dc,
                                    input logic dm, input logic bl);
    exp_t x;
    x.at = at; x.name = name; x.st = st; x.dd = dd; x.dc = dc; x.dm = dm; x.bl = bl;
    sb.push_back(x);
  endfunction

  // Monitor: outputs after edge N are compared at the following negedge.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        ex = sb.pop_front();
        checks++;
        if (ex.at < cyc) begin
          errors++;
          $display("FAIL %s: expectation for edge %0d was not reached in order (now %0d)",
                   ex.name, ex.at, cyc);
        end else if (bus.state !== ex.st || bus.dispDest !== ex.dd || bus.dispCurr !== ex.dc ||
                     bus.displayMode !== ex.dm || bus.blankDest !== ex.bl) begin
          errors++;
          $display("FAIL %s @%0d: got st=%0d dest=%h curr=%h mode=%b blank=%b, want st=%0d dest=%h curr=%h mode=%b blank=%b",
                   ex.name, cyc, bus.state, bus.dispDest, bus.dispCurr, bus.displayMode,
                   bus.blankDest, ex.st, ex.dd, ex.dc, ex.dm, ex.bl);
        end else begin
          $display("ok   %s @%0d: st=%0d dest=%h curr=%h mode=%b blank=%b",
                   ex.name, cyc, bus.state, bus.dispDest, bus.dispCurr, bus.displayMode,
                   bus.blankDest);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Wait until the negedge just before edge c, so inputs set now are sampled at edge c.
  task automatic go(input int c);
    while (cyc < c - 1) @(negedge clock);
  endtask

  initial begin
    int e, a, u, s;
    bus.dest = D; bus.curr = C;
    bus.editReq = 0; bus.editDone = 0; bus.keyActivity = 0;
    bus.alertReq = 0; bus.alertCode = 8'h00; bus.unitToggle = 0;

    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    expect_at(cyc, "reset state", ST_NORMAL, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    expect_at(cyc + 1, "reset release", ST_NORMAL, D, C, 1'b0, 1'b0);
    resetN = 1'b1;

    // Edit entry, blink and timeout
    e = cyc + 3;
    expect_at(e,      "t1 enter",      ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 7,  "t1 blink off",  ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 8,  "t1 blink on",   ST_EDIT,   D, C, 1'b0, 1'b1);
    expect_at(e + 15, "t1 blink on2",  ST_EDIT,   D, C, 1'b0, 1'b1);
    expect_at(e + 16, "t1 blink off2", ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 39, "t1 pre-exit",   ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 40, "t1 timeout",    ST_NORMAL, D, C, 1'b0, 1'b0);
    go(e); bus.editReq = 1; @(negedge clock); bus.editReq = 0;

    // keyActivity restarts timeout and blink phase
    e = e + 45;
    expect_at(e,      "t2 enter",        ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 29, "t2 blink pre",    ST_EDIT,   D, C, 1'b0, 1'b1);
    expect_at(e + 30, "t2 key restart",  ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 38, "t2 blink after",  ST_EDIT,   D, C, 1'b0, 1'b1);
    expect_at(e + 40, "t2 no exit at 40", ST_EDIT,  D, C, 1'b0, 1'b1);
    expect_at(e + 69, "t2 pre-exit",     ST_EDIT,   D, C, 1'b0, 1'b0);
    expect_at(e + 70, "t2 timeout",      ST_NORMAL, D, C, 1'b0, 1'b0);
    go(e);      bus.editReq = 1;     @(negedge clock); bus.editReq = 0;
    go(e + 30); bus.keyActivity = 1; @(negedge clock); bus.keyActivity = 0;

    u = e + 73;
    expect_at(u, "toggle on", ST_NORMAL, D, C, 1'b1, 1'b0);
    go(u); bus.unitToggle = 1; @(negedge clock); bus.unitToggle = 0;

    // Alert interrupting EDIT, then resume with full edit timeout
    e = u + 3;
    a = e + 5;
    expect_at(e,      "t3 enter",       ST_EDIT,   D,  C,  1'b1, 1'b0);
    expect_at(a,      "t3 alert",       ST_ALERT,  E1, E1, 1'b0, 1'b0);
    expect_at(a + 19, "t3 alert hold",  ST_ALERT,  E1, E1, 1'b0, 1'b0);
    expect_at(a + 20, "t3 resume edit", ST_EDIT,   D,  C,  1'b1, 1'b0);
    expect_at(a + 28, "t3 blink",       ST_EDIT,   D,  C,  1'b1, 1'b1);
    expect_at(a + 59, "t3 pre-exit",    ST_EDIT,   D,  C,  1'b1, 1'b0);
    expect_at(a + 60, "t3 timeout",     ST_NORMAL, D,  C,  1'b1, 1'b0);
    go(e); bus.editReq = 1; @(negedge clock); bus.editReq = 0;
    go(a); bus.alertReq = 1; bus.alertCode = E1;
    @(negedge clock); bus.alertReq = 0; bus.alertCode = 8'h00;

    u = a + 63;
    expect_at(u, "toggle off", ST_NORMAL, D, C, 1'b0, 1'b0);
    go(u); bus.unitToggle = 1; @(negedge clock); bus.unitToggle = 0;

    // Re-alert extends the alert; unitToggle hidden until NORMAL
    a = u + 3;
    expect_at(a,      "t4 alert",         ST_ALERT,  E1, E1, 1'b0, 1'b0);
    expect_at(a + 11, "t4 hold",          ST_ALERT,  E1, E1, 1'b0, 1'b0);
    expect_at(a + 12, "t4 relatch",       ST_ALERT,  E2, E2, 1'b0, 1'b0);
    expect_at(a + 15, "t4 mode forced",   ST_ALERT,  E2, E2, 1'b0, 1'b0);
    expect_at(a + 31, "t4 hold2",         ST_ALERT,  E2, E2, 1'b0, 1'b0);
    expect_at(a + 32, "t4 end",           ST_NORMAL, D,  C,  1'b1, 1'b0);
    go(a); bus.alertReq = 1; bus.alertCode = E1;
    @(negedge clock); bus.alertReq = 0; bus.alertCode = 8'h00;
    go(a + 12); bus.alertReq = 1; bus.alertCode = E2;
    @(negedge clock); bus.alertReq = 0; bus.alertCode = 8'h00;
    go(a + 15); bus.unitToggle = 1; @(negedge clock); bus.unitToggle = 0;

    // Simultaneous requests
    s = a + 35;
    expect_at(s,      "t5 alert wins",   ST_ALERT,  A5, A5, 1'b0, 1'b0);
    expect_at(s + 19, "t5 hold",         ST_ALERT,  A5, A5, 1'b0, 1'b0);
    expect_at(s + 20, "t5 resume edit",  ST_EDIT,   D,  C,  1'b1, 1'b0);
    expect_at(s + 24, "t5 edit",         ST_EDIT,   D,  C,  1'b1, 1'b0);
    expect_at(s + 25, "t5 done wins",    ST_NORMAL, D,  C,  1'b1, 1'b0);
    go(s); bus.editReq = 1; bus.alertReq = 1; bus.alertCode = A5;
    @(negedge clock); bus.editReq = 0; bus.alertReq = 0; bus.alertCode = 8'h00;
    go(s + 25); bus.editDone = 1; bus.keyActivity = 1;
    @(negedge clock); bus.editDone = 0; bus.keyActivity = 0;

    // Asynchronous reset in the middle of EDIT
    e = s + 28;
    expect_at(e, "t6 enter", ST_EDIT, D, C, 1'b1, 1'b0);
    go(e); bus.editReq = 1; @(negedge clock); bus.editReq = 0;
    go(e + 6);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    expect_at(cyc,   "t6 async reset", ST_NORMAL, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.dest = 8'h32; bus.curr = 8'h28;
    expect_at(e + 7, "t6 held",  ST_NORMAL, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_at(e + 8, "t6 held2", ST_NORMAL, 8'h00, 8'h00, 1'b0, 1'b0);
    go(e + 9);
    resetN = 1'b1;
    expect_at(e + 9,  "t6 release", ST_NORMAL, 8'h32, 8'h28, 1'b0, 1'b0);
    expect_at(e + 10, "t6 steady",  ST_NORMAL, 8'h32, 8'h28, 1'b0, 1'b0);
    go(e + 13);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequencing controller in front of the 4-digit multiplexed temperature display.
- Chooses what the display shows: setpoint/current pass-through (NORMAL), setpoint-edit with a blinking setpoint (EDIT), or a timed alert code (ALERT).
- Owns the hex/decimal display-mode flag.
- Sits between the temperature control core/keypad logic and the display driver; feeds its dest, curr and displayMode inputs plus a blank control for the setpoint digits.

Parameters:
- TICK_DIV, 50000, clock cycles per tick (1 ms at 50 MHz).
- BLINK_TICKS, 250, ticks per blink half-period in EDIT.
- EDIT_TIMEOUT_TICKS, 5000, ticks without keyActivity before EDIT auto-exits.
- ALERT_TICKS, 2000, ticks an alert stays displayed.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetN  in  1  asynchronous active-low reset.
- dest  in  8  setpoint from the control core.
- curr  in  8  measured temperature.
- editReq  in  1  one-cycle pulse: enter setpoint edit.
- editDone  in  1  one-cycle pulse: leave setpoint edit.
- keyActivity  in  1  one-cycle pulse: any key press; restarts the edit timeout.
- alertReq  in  1  one-cycle pulse: show alertCode.
- alertCode  in  8  code latched on alertReq.
- unitToggle  in  1  one-cycle pulse: toggle the hex/decimal mode.
- dispDest  out  8  value for the setpoint digits.
- dispCurr  out  8  value for the current-temperature digits.
- displayMode  out  1  1 = decimal conversion, 0 = raw hex.
- blankDest  out  1  1 = setpoint digits blanked.
- state  out  2  0 NORMAL, 1 EDIT, 2 ALERT (3 unused).

Behaviour:
- Reset, asynchronous:
  - State and output registers: state=NORMAL, dispDest=0, dispCurr=0, displayMode=0, blankDest=0.
  - Internal registers: modeReg=0, resume=NORMAL, all counters 0.
- Output registering: all outputs are registered. A request sampled at edge k is reflected in the outputs after edge k (1-cycle latency). dest and curr are re-registered every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick on the wrap.
  - Cleared on every state transition, on an accepted keyActivity in EDIT, and on alertReq in ALERT.
  - Intervals are therefore exact: N ticks = N*TICK_DIV cycles.
- NORMAL:
  - dispDest=dest, dispCurr=curr, displayMode=modeReg, blankDest=0.
  - editReq → EDIT. alertReq → ALERT with resume=NORMAL.
- EDIT:
  - dispDest=dest, dispCurr=curr, displayMode=modeReg.
  - blankDest is 0 on entry and toggles every BLINK_TICKS ticks.
  - Edit timer counts ticks.
  - editDone → NORMAL.
  - keyActivity restarts the edit timer, the prescaler and the blink phase (blankDest=0).
  - EDIT_TIMEOUT_TICKS ticks with no keyActivity → NORMAL.
  - alertReq → ALERT with resume=EDIT.
  - editReq in EDIT behaves as keyActivity.
- ALERT:
  - dispDest=alertCode latch, dispCurr=alertCode latch, displayMode=0 (forced), blankDest=0.
  - ALERT_TICKS ticks → state=resume. Resuming EDIT restarts the edit timer and blink phase in full.
  - alertReq in ALERT re-latches the code and restarts the alert timer; resume is unchanged.
  - editReq in ALERT sets resume=EDIT. editDone in ALERT sets resume=NORMAL.
  - keyActivity is ignored in ALERT.
- unitToggle: inverts modeReg in any state. The inversion is visible on displayMode only outside ALERT.
- Simultaneous pulses in one cycle, priority: alertReq > editDone > editReq > keyActivity. Only the highest-priority event that changes state is acted on. unitToggle is always applied.
- Timer expiry and a request in the same cycle: the request wins; the timer does not act.
- Counter widths: sized with clog2 of the parameter, with no overflow. Parameters must be ≥1.

Decomposition:
- Shared display package: state encoding constants (ST_NORMAL=0, ST_EDIT=1, ST_ALERT=2) and default timing constants. Both this block and the tests use them.
- One sub-module: tick_prescaler (parameter DIV; inputs clock, resetN, clear; output tick).
- Blink, edit and alert timers stay inline in display_scheduler.

Test Plan (TICK_DIV=4, BLINK_TICKS=2, EDIT_TIMEOUT_TICKS=10, ALERT_TICKS=5):
- Reset mid-EDIT: assert resetN=0 while in EDIT → all outputs 0 immediately, state=0. Release with dest=0x32, curr=0x28 → dispDest=0x32, dispCurr=0x28 one cycle later.
- editReq, then idle: blankDest=0 for 8 cycles, then 1 for 8, alternating. Return to state=0 exactly 40 cycles after entry, with blankDest=0.
- In EDIT, keyActivity at cycle 30: no exit at 40. Exit at cycle 70. blankDest=0 right after the pulse.
- In EDIT, alertReq with alertCode=0xE1: state=2, dispDest=dispCurr=0xE1, displayMode=0. After 20 cycles state=1, and timeout occurs 40 cycles later.
- alertReq at cycle 0, and again at cycle 12 with code 0xE2: code changes to 0xE2 and ALERT ends at cycle 32. Also, unitToggle during ALERT: displayMode stays 0, then reads 1 after returning to NORMAL.
- Same cycle editReq+alertReq from NORMAL: state=2, resume=EDIT. editDone+keyActivity in EDIT: state=0.
